// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MULT/MULTU/DIV/DIVU unit for the MIPS EX stage.
// One bit per cycle: shift-add multiply and restoring divide share one
// 2*WIDTH accumulator. HI/LO hold the last result for MFHI/MFLO.
// Optional feature macro: MDU_DIV_EN builds the divide datapath. Without it,
// DIV/DIVU complete immediately and leave HI/LO untouched.
//
// Handshake: start is sampled only in IDLE or DONE (ignored while busy).
// busy is high for exactly WIDTH cycles in RUN; done pulses for one cycle in
// the cycle HI/LO take the new result; busy and done never overlap. All
// handshake outputs are registered.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       MDoperation,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             divByZero,
    output logic [1:0]       dbg_state
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;      // mult: {partial, multiplier}; div: {rem, quotient}
    logic [WIDTH-1:0]   mcand;    // multiplicand or divisor magnitude
    logic               res_neg;  // product / quotient must be negated

    logic               op_signed;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic               skip_run;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [2*WIDTH-1:0] acc_next;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   hi_res;
    logic [WIDTH-1:0]   lo_res;
    logic               dz_res;

`ifdef MDU_DIV_EN
    logic               is_div;
    logic               rem_neg;  // remainder follows the dividend sign
    logic               dz;       // divisor was zero
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_rem;
    logic [2*WIDTH-1:0] div_next;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
`endif

    assign dbg_state = state;

    // Without the divide datapath, DIV/DIVU bypass RUN entirely
`ifdef MDU_DIV_EN
    assign skip_run = 1'b0;
`else
    assign skip_run = MDoperation[1];
`endif

    // Operand magnitudes and sign flags for signed ops
    always_comb begin
        op_signed = ~MDoperation[0];
        a_neg     = op_signed & A[WIDTH-1];
        b_neg     = op_signed & B[WIDTH-1];
        a_mag     = a_neg ? -A : A;
        b_mag     = b_neg ? -B : B;
    end

    // One iteration of shift-add multiply or restoring divide
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]}
                 + (acc[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
        mul_next = {mul_sum, acc[WIDTH-1:1]};
`ifdef MDU_DIV_EN
        // Remainder is always below the divisor, so the subtract fits WIDTH bits
        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, mcand});
        div_rem   = div_ge ? (div_shift[WIDTH-1:0] - mcand) : div_shift[WIDTH-1:0];
        div_next  = {div_rem, acc[WIDTH-2:0], div_ge};
        acc_next  = is_div ? div_next : mul_next;
`else
        acc_next  = mul_next;
`endif
    end

    // Sign-corrected result as it will be written on the final iteration
    always_comb begin
        prod   = res_neg ? -acc_next : acc_next;
        hi_res = prod[2*WIDTH-1:WIDTH];
        lo_res = prod[WIDTH-1:0];
        dz_res = 1'b0;
`ifdef MDU_DIV_EN
        quo = acc_next[WIDTH-1:0];
        rem = acc_next[2*WIDTH-1:WIDTH];
        if (is_div) begin
            // Zero divisor: remainder equals |A|, so restoring its sign yields A
            hi_res = rem_neg ? -rem : rem;
            lo_res = dz ? {WIDTH{1'b1}} : (res_neg ? -quo : quo);
            dz_res = dz;
        end
`endif
    end

    // Control FSM, iteration registers and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            acc       <= '0;
            mcand     <= '0;
            res_neg   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            divByZero <= 1'b0;
            HI        <= '0;
            LO        <= '0;
`ifdef MDU_DIV_EN
            is_div    <= 1'b0;
            rem_neg   <= 1'b0;
            dz        <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    done      <= 1'b0;
                    divByZero <= 1'b0;
                    if (start && skip_run) begin
                        // Divide without hardware: one done pulse, HI/LO held
                        done  <= 1'b1;
                        state <= DONE;
                    end else if (start) begin
                        res_neg <= a_neg ^ b_neg;
                        cnt     <= CW'(WIDTH - 1);
`ifdef MDU_DIV_EN
                        is_div  <= MDoperation[1];
                        rem_neg <= a_neg;
                        dz      <= MDoperation[1] & (B == '0);
                        if (MDoperation[1]) begin
                            acc   <= {{WIDTH{1'b0}}, a_mag};
                            mcand <= b_mag;
                        end else begin
                            acc   <= {{WIDTH{1'b0}}, b_mag};
                            mcand <= a_mag;
                        end
`else
                        acc     <= {{WIDTH{1'b0}}, b_mag};
                        mcand   <= a_mag;
`endif
                        busy    <= 1'b1;
                        state   <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    acc <= acc_next;
                    cnt <= cnt - CW'(1);
                    if (cnt == '0) begin
                        HI        <= hi_res;
                        LO        <= lo_res;
                        divByZero <= dz_res;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Multi-cycle integer multiply/divide unit for the MIPS pipeline, sitting beside the single-cycle ALU in the EX stage. It accepts MULT, MULTU, DIV and DIVU requests from the ID/EX stage through a start/busy/done handshake. It iterates one bit per cycle and holds the 64-bit result in HI/LO registers for MFHI/MFLO. The hazard unit stalls on `busy`.

## Interface
- `WIDTH`, default 32: operand width; HI/LO are each `WIDTH` bits.
- `clk`, in, 1: single clock; all state changes on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: request strobe; sampled only in IDLE or DONE.
- `MDoperation`, in, 2: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- `A`, in, `WIDTH`: multiplicand / dividend (rs).
- `B`, in, `WIDTH`: multiplier / divisor (rt).
- `busy`, out, 1: high while iterating (RUN state).
- `done`, out, 1: high for exactly one cycle when HI/LO take the new result.
- `HI`, out, `WIDTH`: product upper half / remainder.
- `LO`, out, `WIDTH`: product lower half / quotient.
- `divByZero`, out, 1: high together with `done` when a divide had B = 0.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- All outputs reset to 0.
- IDLE, `start`=1: latch operands and the op. Take magnitudes for signed ops. Record the result signs. Load the counter with `WIDTH`-1. Go to RUN.
- RUN: one iteration per cycle; the counter decrements each cycle.
  - Multiply: shift-add on a 2×`WIDTH` accumulator.
  - Divide: restoring; a shift, a trial subtract, and one quotient bit per cycle.
- RUN, counter = 0: final iteration. Write the sign-corrected result to HI/LO. Go to DONE.
- Signed results:
  - Product is negated when the operand signs differ.
  - Quotient is negated when the signs differ.
  - Remainder takes the sign of the dividend.
- Arithmetic is modulo 2^`WIDTH`, so −2^31 / −1 gives LO = 0x80000000 and HI = 0.
- Divide by zero (signed or unsigned): HI = A, LO = all ones, `divByZero` = 1 in the DONE cycle.
- DONE: `done`=1.
  - `start`=1 here: accepted like IDLE, go straight to RUN (back-to-back).
  - `start`=0: go to IDLE.
- `start` while in RUN is ignored. The operands and the op in flight are not disturbed.
- HI/LO change only on entry to DONE. They hold their value in all other states.

## Timing
- `start` is sampled at edge E0.
- `busy` is high from after E0 through edge E32: `WIDTH` cycles in RUN.
- HI/LO update at E32. `done` and `divByZero` are high between E32 and E33.
- Total latency from the start edge to valid HI/LO: `WIDTH` cycles. Throughput: one op per `WIDTH`+1 cycles.
- `busy` and `done` are never high in the same cycle.
- `busy`, `done` and `divByZero` are registered outputs; there is no combinational path from inputs.
- `rst_n` low at any time (mid-RUN included):
  - State returns to IDLE immediately, not waiting for a clock edge.
  - All outputs, HI and LO read 0.
  - The partial result is discarded.
  - The first `start` after `rst_n` rises is processed normally.

## Configuration
- `MDU_DIV_EN` defined: full behaviour as above.
- `MDU_DIV_EN` undefined: divide hardware is not built.
  - DIV/DIVU go IDLE→DONE at the start edge, with no RUN cycles and `busy` staying 0.
  - HI/LO keep their previous values, `divByZero` = 0, `done` pulses for one cycle.
- MULT/MULTU are unchanged either way.

## Test plan
- MULT, A=0xFFFFFFFD (−3), B=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; `busy` high 32 cycles; `done` in cycle 33 after start.
- MULTU, A=B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; then MULT with the same operands -> HI=0, LO=1.
- DIV, A=0xFFFFFFF9 (−7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU, A=100, B=7 -> LO=14, HI=2.
- DIVU and DIV, A=5, B=0 -> HI=5, LO=0xFFFFFFFF, `divByZero`=1 only in the `done` cycle; without `MDU_DIV_EN`: HI/LO unchanged, `done` one cycle after start.
- Back-to-back and blocked starts:
  - `start` pulsed mid-RUN with different operands -> ignored, the first result is unchanged.
  - `start` in the DONE cycle -> second op starts with no IDLE cycle; its `done` comes 33 cycles later.
- Reset mid-run: `rst_n` low 10 cycles into a MULT -> `busy`, `done`, HI and LO are 0 before the next edge; after release, DIVU 9/4 -> LO=2, HI=1.
